uart_rx_cfg: RTL

Run-time configurable UART receiver. Word length (5-9 bits), parity (none/even/odd) and stop bits (1/2) are selectable. Bit decisions use 3-sample majority voting. Each received word is delivered through a valid/ready holding register, with per-word parity/framing/break status and a sticky overrun flag. It sits behind the shared baud-tick generator and feeds the UART host interface, replacing the fixed 8-bit even-parity receiver.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/uart_rx_sampler.sv | 75 +++++++
 rtl/uart_rx_cfg.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants, state encoding and helpers (RX and TX).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int         c_st_w       = 7;
    localparam logic [6:0] c_st_idle    = 7'b000_0001;
    localparam logic [6:0] c_st_start   = 7'b000_0010;
    localparam logic [6:0] c_st_data    = 7'b000_0100;
    localparam logic [6:0] c_st_parity  = 7'b000_1000;
    localparam logic [6:0] c_st_stop1   = 7'b001_0000;
    localparam logic [6:0] c_st_stop2   = 7'b010_0000;
    localparam logic [6:0] c_st_wait_hi = 7'b100_0000;

    function automatic int mid_sample(input int over_sample);
        return over_sample / 2;
    endfunction

    // Out-of-range word lengths fall back to 8, then clamp to the data width.
    function automatic logic [3:0] eff_data_bits(input logic [3:0] cfg, input int max_bits);
        logic [3:0] b;
        b = (cfg < 4'd5 || cfg > 4'd9) ? 4'd8 : cfg;
        if (int'(b) > max_bits) b = 4'(max_bits);
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sampler.sv
// ============================================================================
// Module      : uart_rx_sampler
// Description : Line synchroniser, start-edge detect, tick counter, 3-sample vote.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVER_SAMPLE = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    input  logic tick,
    input  logic cnt_clr,
    output logic rxs,
    output logic start_edge,
    output logic bit_done,
    output logic bit_val
);

    localparam int                 c_cnt_w = $clog2(OVER_SAMPLE);
    localparam int                 c_mid   = mid_sample(OVER_SAMPLE);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(OVER_SAMPLE - 1);
    localparam logic [c_cnt_w-1:0] c_s0    = c_cnt_w'(c_mid - 1);
    localparam logic [c_cnt_w-1:0] c_s1    = c_cnt_w'(c_mid);
    localparam logic [c_cnt_w-1:0] c_s2    = c_cnt_w'(c_mid + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rxs_prev;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [2:0]             r_votes;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync     <= '1;
            r_rxs_prev <= 1'b1;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], rx_i};
            r_rxs_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_votes <= 3'b111;
        end else if (tick) begin
            if (r_cnt == c_s0) r_votes[0] <= rxs;
            if (r_cnt == c_s1) r_votes[1] <= rxs;
            if (r_cnt == c_s2) r_votes[2] <= rxs;
        end
    end

    assign rxs        = r_sync[SYNC_STAGES-1];
    assign start_edge = r_rxs_prev & ~rxs;
    assign bit_done   = tick & (r_cnt == c_last);
    assign bit_val    = (r_votes[0] & r_votes[1]) | (r_votes[0] & r_votes[2]) |
                        (r_votes[1] & r_votes[2]);

endmodule

`default_nettype wire

// File: rtl/uart_rx_cfg.sv
// ============================================================================
// Module      : uart_rx_cfg
// Description : Run-time configurable UART receiver with valid/ready holding reg.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS_MAX = 9,
    parameter int OVER_SAMPLE   = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_i,
    input  logic                     tick,
    input  logic [3:0]               cfg_data_bits,
    input  logic [1:0]               cfg_parity,
    input  logic                     cfg_stop2,
    output logic [DATA_BITS_MAX-1:0] rx_data,
    output logic                     rx_parity_err,
    output logic                     rx_frame_err,
    output logic                     rx_break,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic                     overrun,
    input  logic                     overrun_clr
);

    logic w_rxs, w_start_edge, w_bit_done, w_bit_val;
    logic w_cnt_clr, w_complete, w_fin_brk, w_fin_ferr;
    logic w_par_en, w_last_data, w_accept;

    logic [c_st_w-1:0]        r_state, w_state_nxt;
    logic [3:0]               r_bits;
    logic [1:0]               r_par_mode;
    logic                     r_stop2;
    logic [3:0]               r_idx;
    logic [DATA_BITS_MAX-1:0] r_shift;
    logic                     r_par_acc, r_all_zero, r_par_err;
    logic                     r_valid, r_overrun;

    uart_rx_sampler #(
        .OVER_SAMPLE (OVER_SAMPLE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .clk        (clk),
        .rst        (rst),
        .rx_i       (rx_i),
        .tick       (tick),
        .cnt_clr    (w_cnt_clr),
        .rxs        (w_rxs),
        .start_edge (w_start_edge),
        .bit_done   (w_bit_done),
        .bit_val    (w_bit_val)
    );

    assign w_par_en    = (r_par_mode == PAR_EVEN) || (r_par_mode == PAR_ODD);
    assign w_last_data = (r_idx == r_bits - 4'd1);
    assign w_accept    = r_valid & rx_ready;
    // Every completing decision is a stop bit, so its framing status is the vote itself.
    assign w_fin_ferr  = ~w_bit_val;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= c_st_idle;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:    if (w_start_edge) w_state_nxt = c_st_start;
            c_st_start:   if (w_bit_done) w_state_nxt = w_bit_val ? c_st_idle : c_st_data;
            c_st_data:    if (w_bit_done && w_last_data)
                              w_state_nxt = w_par_en ? c_st_parity : c_st_stop1;
            c_st_parity:  if (w_bit_done) w_state_nxt = c_st_stop1;
            c_st_stop1:   if (w_bit_done) begin
                              if (r_stop2 && w_bit_val) w_state_nxt = c_st_stop2;
                              else w_state_nxt = w_rxs ? c_st_idle : c_st_wait_hi;
                          end
            c_st_stop2:   if (w_bit_done) w_state_nxt = w_rxs ? c_st_idle : c_st_wait_hi;
            c_st_wait_hi: if (w_rxs) w_state_nxt = c_st_idle;
            default:      w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        w_cnt_clr  = 1'b0;
        w_complete = 1'b0;
        w_fin_brk  = 1'b0;
        case (r_state)
            c_st_idle:  w_cnt_clr = w_start_edge;
            c_st_stop1: begin
                w_complete = w_bit_done & ~(r_stop2 & w_bit_val);
                w_fin_brk  = r_all_zero & ~w_bit_val;
            end
            c_st_stop2: w_complete = w_bit_done;
            default:    ;
        endcase
    end

    // Frame configuration is frozen at the start edge for the whole frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bits     <= 4'd8;
            r_par_mode <= PAR_NONE;
            r_stop2    <= 1'b0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_par_acc  <= 1'b0;
            r_all_zero <= 1'b1;
            r_par_err  <= 1'b0;
        end else if (w_cnt_clr) begin
            r_bits     <= eff_data_bits(cfg_data_bits, DATA_BITS_MAX);
            r_par_mode <= (cfg_parity == 2'b11) ? PAR_NONE : cfg_parity;
            r_stop2    <= cfg_stop2;
            r_idx      <= '0;
            r_shift    <= '0;
            r_par_acc  <= 1'b0;
            r_all_zero <= 1'b1;
            r_par_err  <= 1'b0;
        end else if (w_bit_done) begin
            case (r_state)
                c_st_data: begin
                    for (int i = 0; i < DATA_BITS_MAX; i++) begin
                        if (r_idx == 4'(i)) r_shift[i] <= w_bit_val;
                    end
                    r_idx     <= r_idx + 4'd1;
                    r_par_acc <= r_par_acc ^ w_bit_val;
                    if (w_bit_val) r_all_zero <= 1'b0;
                end
                c_st_parity: begin
                    r_par_err <= w_bit_val ^ r_par_acc ^ (r_par_mode == PAR_ODD);
                    if (w_bit_val) r_all_zero <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // A completion in the same cycle as an accept replaces the word rather than overrunning.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid       <= 1'b0;
            rx_data       <= '0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_break      <= 1'b0;
        end else if (w_complete && (!r_valid || rx_ready)) begin
            r_valid       <= 1'b1;
            rx_data       <= r_shift;
            rx_parity_err <= r_par_err;
            rx_frame_err  <= w_fin_ferr;
            rx_break      <= w_fin_brk;
        end else if (w_accept) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                   r_overrun <= 1'b0;
        else if (w_complete && r_valid && !rx_ready) r_overrun <= 1'b1;
        else if (overrun_clr)                       r_overrun <= 1'b0;
    end

    assign rx_valid = r_valid;
    assign overrun  = r_overrun;

endmodule

`default_nettype wire
